// File: rtl/cell_scanner.sv
// cell_scanner: walks a fixed 8x8 board once per scan_start and presents one
// cell per accepted handshake (idx 0..63). Each cell carries its display code
// (hidden / revealed mine / adjacent mine count). At the end of the scan the
// registered game_lost / game_won result is loaded.
//
// Optional feature: define CELL_SCANNER_CURSOR_MARK_EN to flag the cursor cell
// on cell_cursor. When the macro is undefined, cell_cursor is tied to 0 and no
// cursor snapshot is kept.
module cell_scanner (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_start,
    input  logic [63:0] clicked_flat,
    input  logic [63:0] mine_flat,
    input  logic [2:0]  cursor_X,
    input  logic [2:0]  cursor_Y,
    input  logic        cell_ready,
    output logic        busy,
    output logic        cell_valid,
    output logic [5:0]  cell_idx,
    output logic [3:0]  cell_code,
    output logic        cell_cursor,
    output logic        scan_done,
    output logic        game_lost,
    output logic        game_won
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] CODE_MINE   = 4'hE;
    localparam logic [3:0] CODE_HIDDEN = 4'hF;
    localparam logic [5:0] IDX_LAST    = 6'd63;
    localparam logic [6:0] NUM_CELLS   = 7'd64;

    state_t      state;
    logic [5:0]  idx;
    logic [63:0] snap_clicked;
    logic [63:0] snap_mine;
    logic        lost;
    logic [6:0]  mine_cnt;
    logic [6:0]  safe_cnt;

    logic        accept;
    logic        cur_clicked;
    logic        cur_mine;
    logic [3:0]  nbr_mines;

    // Count mines among the up-to-8 neighbours of cell i; off-board
    // positions are skipped so the board never wraps at its edges.
    function automatic logic [3:0] nbr_count(input logic [63:0] m, input logic [5:0] i);
        logic [3:0] n;
        logic [5:0] b;
        int         cx, cy, nx, ny;
        n  = '0;
        b  = '0;
        cx = int'(i[5:3]);
        cy = int'(i[2:0]);
        for (int dx = -1; dx <= 1; dx++) begin
            for (int dy = -1; dy <= 1; dy++) begin
                nx = cx + dx;
                ny = cy + dy;
                if (!(dx == 0 && dy == 0) && nx >= 0 && nx < 8 && ny >= 0 && ny < 8) begin
                    b = 6'(nx * 8 + ny);
                    n = n + {3'b000, m[b]};
                end
            end
        end
        return n;
    endfunction

    assign accept      = (state == S_SCAN) && cell_ready;
    assign cur_clicked = snap_clicked[idx];
    assign cur_mine    = snap_mine[idx];
    assign nbr_mines   = nbr_count(snap_mine, idx);
    assign busy        = (state != S_IDLE);

    // Scan sequencing, snapshot capture, per-cell tallies and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            snap_clicked <= '0;
            snap_mine    <= '0;
            lost         <= 1'b0;
            mine_cnt     <= '0;
            safe_cnt     <= '0;
            scan_done    <= 1'b0;
            game_lost    <= 1'b0;
            game_won     <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (scan_start) state <= S_LATCH;
                end
                S_LATCH: begin
                    snap_clicked <= clicked_flat;
                    snap_mine    <= mine_flat;
                    idx          <= '0;
                    lost         <= 1'b0;
                    mine_cnt     <= '0;
                    safe_cnt     <= '0;
                    state        <= S_SCAN;
                end
                S_SCAN: begin
                    if (accept) begin
                        if (cur_clicked && cur_mine)  lost     <= 1'b1;
                        if (cur_mine)                 mine_cnt <= mine_cnt + 7'd1;
                        if (cur_clicked && !cur_mine) safe_cnt <= safe_cnt + 7'd1;
                        if (idx == IDX_LAST) begin
                            // idx stays at 63; the pulse lines up with DONE
                            state     <= S_DONE;
                            scan_done <= 1'b1;
                        end else begin
                            idx <= idx + 6'd1;
                        end
                    end
                end
                S_DONE: begin
                    game_lost <= lost;
                    game_won  <= !lost && (safe_cnt == (NUM_CELLS - mine_cnt));
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Present the cell at idx straight from the snapshot while scanning.
    always_comb begin
        cell_valid = (state == S_SCAN);
        cell_idx   = '0;
        cell_code  = '0;
        if (cell_valid) begin
            cell_idx = idx;
            if (!cur_clicked)  cell_code = CODE_HIDDEN;
            else if (cur_mine) cell_code = CODE_MINE;
            else               cell_code = nbr_mines;
        end
    end

`ifdef CELL_SCANNER_CURSOR_MARK_EN
    logic [2:0] snap_cx;
    logic [2:0] snap_cy;

    // Cursor position is frozen with the maps so the mark is stable mid-scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_cx <= '0;
            snap_cy <= '0;
        end else if (state == S_LATCH) begin
            snap_cx <= cursor_X;
            snap_cy <= cursor_Y;
        end
    end

    assign cell_cursor = cell_valid && (idx == {snap_cx, snap_cy});
`else
    logic unused_cursor;
    assign unused_cursor = ^{cursor_X, cursor_Y};
    assign cell_cursor   = 1'b0;
`endif

endmodule

// File: tb/tb_cell_scanner.sv
// Directed bench for cell_scanner: fixed board patterns with hand-derived
// expected codes, handshake stalls with live inputs changing, and reset abort.
module tb_cell_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_start;
    logic [63:0] clicked_flat;
    logic [63:0] mine_flat;
    logic [2:0]  cursor_X;
    logic [2:0]  cursor_Y;
    logic        cell_ready;
    logic        busy;
    logic        cell_valid;
    logic [5:0]  cell_idx;
    logic [3:0]  cell_code;
    logic        cell_cursor;
    logic        scan_done;
    logic        game_lost;
    logic        game_won;

    int n_chk = 0;
    int n_err = 0;

    logic [3:0] exp_code [64];
    logic [3:0] got_code [64];

`ifdef CELL_SCANNER_CURSOR_MARK_EN
    localparam int CUR_CNT_EXP = 1;
    localparam int CUR_AT_EXP  = 21;
`else
    localparam int CUR_CNT_EXP = 0;
    localparam int CUR_AT_EXP  = 99;
`endif

    cell_scanner dut (
        .clk          (clk),
        .rst          (rst),
        .scan_start   (scan_start),
        .clicked_flat (clicked_flat),
        .mine_flat    (mine_flat),
        .cursor_X     (cursor_X),
        .cursor_Y     (cursor_Y),
        .cell_ready   (cell_ready),
        .busy         (busy),
        .cell_valid   (cell_valid),
        .cell_idx     (cell_idx),
        .cell_code    (cell_code),
        .cell_cursor  (cell_cursor),
        .scan_done    (scan_done),
        .game_lost    (game_lost),
        .game_won     (game_won)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_fill(input logic [3:0] v);
        for (int i = 0; i < 64; i++) exp_code[i] = v;
    endtask

    // One full scan; stalls s_len cycles at s_idx (maps/cursor flipped mid-stall),
    // pokes scan_start while busy, then checks codes, timing and result flags.
    task automatic run_scan(input string nm, input int s_idx, input int s_len,
                            input logic exp_lost, input logic exp_won);
        int ncyc, nexp, ord_err, hold_err, stalls, cur_cnt, cur_at, extra;
        logic [3:0] held_code;
        ncyc = 0; nexp = 0; ord_err = 0; hold_err = 0; stalls = 0;
        cur_cnt = 0; cur_at = 99; extra = 0; held_code = '0;
        for (int i = 0; i < 64; i++) got_code[i] = 4'h0;
        cursor_X = 3'd2;
        cursor_Y = 3'd5;
        cell_ready = 1'b1;
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        ncyc = 1;
        chk({nm, ":latch_busy"}, 64'(busy), 64'd1);
        chk({nm, ":latch_valid"}, 64'(cell_valid), 64'd0);
        while (!scan_done && ncyc < 400) begin
            scan_start = 1'b0;
            if (cell_valid) begin
                scan_start = (cell_idx == 6'd10);
                if (int'(cell_idx) == s_idx && stalls < s_len) begin
                    if (stalls == 0) held_code = cell_code;
                    else if (cell_code !== held_code) hold_err++;
                    if (stalls == 2) begin
                        clicked_flat = ~clicked_flat;
                        mine_flat    = ~mine_flat;
                        cursor_X     = ~cursor_X;
                        cursor_Y     = ~cursor_Y;
                    end
                    cell_ready = 1'b0;
                    stalls++;
                end else begin
                    if (cell_idx != 6'(nexp)) ord_err++;
                    got_code[cell_idx] = cell_code;
                    if (cell_cursor) begin
                        cur_cnt++;
                        cur_at = int'(cell_idx);
                    end
                    nexp++;
                    cell_ready = 1'b1;
                end
            end
            @(posedge clk); #1;
            ncyc++;
        end
        scan_start = 1'b0;
        cell_ready = 1'b1;
        chk({nm, ":done_cycle"}, 64'(ncyc), 64'(66 + s_len));
        chk({nm, ":done_valid"}, 64'(cell_valid), 64'd0);
        chk({nm, ":done_busy"}, 64'(busy), 64'd1);
        chk({nm, ":order"}, 64'(ord_err), 64'd0);
        chk({nm, ":cells"}, 64'(nexp), 64'd64);
        chk({nm, ":hold"}, 64'(hold_err), 64'd0);
        for (int i = 0; i < 64; i++)
            chk($sformatf("%s:code[%0d]", nm, i), 64'(got_code[i]), 64'(exp_code[i]));
        chk({nm, ":cursor_cnt"}, 64'(cur_cnt), 64'(CUR_CNT_EXP));
        chk({nm, ":cursor_at"}, 64'(cur_at), 64'(CUR_AT_EXP));
        @(posedge clk); #1;
        chk({nm, ":idle_busy"}, 64'(busy), 64'd0);
        chk({nm, ":pulse_len"}, 64'(scan_done), 64'd0);
        chk({nm, ":lost"}, 64'(game_lost), 64'(exp_lost));
        chk({nm, ":won"}, 64'(game_won), 64'(exp_won));
        // the scan_start poked mid-scan must not have been queued
        repeat (3) begin
            @(posedge clk); #1;
            if (busy) extra++;
        end
        chk({nm, ":no_queue"}, 64'(extra), 64'd0);
    endtask

    initial begin
        int waited, seen;
        rst          = 1'b1;
        scan_start   = 1'b0;
        clicked_flat = '0;
        mine_flat    = '0;
        cursor_X     = '0;
        cursor_Y     = '0;
        cell_ready   = 1'b1;
        #1;
        chk("rst:busy",   64'(busy), 64'd0);
        chk("rst:valid",  64'(cell_valid), 64'd0);
        chk("rst:idx",    64'(cell_idx), 64'd0);
        chk("rst:code",   64'(cell_code), 64'd0);
        chk("rst:cursor", 64'(cell_cursor), 64'd0);
        chk("rst:done",   64'(scan_done), 64'd0);
        chk("rst:lost",   64'(game_lost), 64'd0);
        chk("rst:won",    64'(game_won), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // empty board, nothing revealed
        clicked_flat = '0;
        mine_flat    = '0;
        exp_fill(4'hF);
        run_scan("empty", -1, 0, 1'b0, 1'b0);

        // single mine at (1,1), everything revealed
        clicked_flat = '1;
        mine_flat    = 64'd1 << 9;
        exp_fill(4'h0);
        exp_code[0] = 4'h1;  exp_code[1] = 4'h1;  exp_code[2] = 4'h1;
        exp_code[8] = 4'h1;  exp_code[10] = 4'h1;
        exp_code[16] = 4'h1; exp_code[17] = 4'h1; exp_code[18] = 4'h1;
        exp_code[9] = 4'hE;
        run_scan("mine9", -1, 0, 1'b1, 1'b0);

        // corner mines hidden, every safe cell revealed
        mine_flat    = (64'd1 << 0) | (64'd1 << 63);
        clicked_flat = ~mine_flat;
        exp_fill(4'h0);
        exp_code[0] = 4'hF;  exp_code[63] = 4'hF;
        exp_code[1] = 4'h1;  exp_code[8] = 4'h1;  exp_code[9] = 4'h1;
        exp_code[54] = 4'h1; exp_code[55] = 4'h1; exp_code[62] = 4'h1;
        run_scan("corners", -1, 0, 1'b0, 1'b1);

        // stall at idx 20 with live inputs flipped; results follow the snapshot
        clicked_flat = '1;
        mine_flat    = 64'd1 << 9;
        exp_fill(4'h0);
        exp_code[0] = 4'h1;  exp_code[1] = 4'h1;  exp_code[2] = 4'h1;
        exp_code[8] = 4'h1;  exp_code[10] = 4'h1;
        exp_code[16] = 4'h1; exp_code[17] = 4'h1; exp_code[18] = 4'h1;
        exp_code[9] = 4'hE;
        run_scan("stall", 20, 5, 1'b1, 1'b0);

        // full-reveal board with no mines at all is a win
        clicked_flat = '1;
        mine_flat    = '0;
        exp_fill(4'h0);
        run_scan("nomine", -1, 0, 1'b0, 1'b1);

        // reset in the middle of a scan
        clicked_flat = '1;
        mine_flat    = 64'd1 << 9;
        scan_start   = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        waited = 0;
        while (!(cell_valid && cell_idx == 6'd30) && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("abort:reach30", 64'(waited < 200), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort:busy",   64'(busy), 64'd0);
        chk("abort:valid",  64'(cell_valid), 64'd0);
        chk("abort:idx",    64'(cell_idx), 64'd0);
        chk("abort:code",   64'(cell_code), 64'd0);
        chk("abort:lost",   64'(game_lost), 64'd0);
        chk("abort:won",    64'(game_won), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (scan_done || busy) seen++;
        end
        chk("abort:quiet", 64'(seen), 64'd0);
        chk("abort:lost_after", 64'(game_lost), 64'd0);

        // a fresh scan_start after reset runs normally
        mine_flat    = (64'd1 << 0) | (64'd1 << 63);
        clicked_flat = ~mine_flat;
        exp_fill(4'h0);
        exp_code[0] = 4'hF;  exp_code[63] = 4'hF;
        exp_code[1] = 4'h1;  exp_code[8] = 4'h1;  exp_code[9] = 4'h1;
        exp_code[54] = 4'h1; exp_code[55] = 4'h1; exp_code[62] = 4'h1;
        run_scan("restart", -1, 0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
